// File: rtl/ptmch_spi_gen_if.sv
// Command/status and SPI pin bundle for the pattern-match SPI command generator.
// Latency: none, this is pure wiring between the requester, the generator and the pins.
// Backpressure: the requester must treat CMD_BUSY high as "request will be dropped".
interface ptmch_spi_gen_if;
   logic        CMD_REQ;
   logic [7:0]  CMD_OPCODE;
   logic [23:0] CMD_ADDR;
   logic [1:0]  CMD_ADDR_BYTES;
   logic        CMD_HAS_DATA;
   logic [7:0]  CMD_DATA;
   logic        CMD_BUSY;
   logic        CMD_DONE;
   logic        SPI_CS;
   logic        SPI_CLK;
   logic        SPI_MOSI;

   // Requester side: issues commands, watches status and the bus.
   modport master (
      output CMD_REQ, CMD_OPCODE, CMD_ADDR, CMD_ADDR_BYTES, CMD_HAS_DATA, CMD_DATA,
      input  CMD_BUSY, CMD_DONE, SPI_CS, SPI_CLK, SPI_MOSI
   );

   // Generator side: consumes commands, drives status and the SPI pins.
   modport slave (
      input  CMD_REQ, CMD_OPCODE, CMD_ADDR, CMD_ADDR_BYTES, CMD_HAS_DATA, CMD_DATA,
      output CMD_BUSY, CMD_DONE, SPI_CS, SPI_CLK, SPI_MOSI
   );
endinterface

// File: rtl/ptmch_spi_gen.sv
// SPI mode-0 command generator: opcode + 0..3 address bytes + optional data byte, MSB first.
// Latency: CS falls one cycle after acceptance; CMD_DONE at 1+CLK_DIV*(1+2N)+CS_GAP cycles.
// Backpressure: CMD_REQ is sampled only in IDLE; requests while busy are dropped, never queued.
module ptmch_spi_gen #(
   parameter int unsigned CLK_DIV = 4,
   parameter int unsigned CS_GAP  = 4
) (
   input  logic           CLK100M,
   input  logic           RESET,
   ptmch_spi_gen_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      SETUP    = 3'd1,
      SHIFT_HI = 3'd2,
      SHIFT_LO = 3'd3,
      GAP      = 3'd4
   } state_t;

   localparam logic [15:0] DIV_LOAD = 16'(CLK_DIV - 1);
   localparam logic [15:0] GAP_LOAD = 16'(CS_GAP - 1);

   state_t      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [5:0]  bits_q, bits_d;
   logic [39:0] sh_q, sh_d;
   logic        cs_q, cs_d;
   logic        sck_q, sck_d;
   logic        mosi_q, mosi_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic [39:0] frame;
   logic [5:0]  frame_len;

   // Build the left-aligned frame image (opcode, address bytes MSB first, data) and its bit length.
   always_comb begin
      frame = {bus.CMD_OPCODE, 32'h0};
      case (bus.CMD_ADDR_BYTES)
         2'd0: ;
         2'd1: frame[31:24] = bus.CMD_ADDR[7:0];
         2'd2: frame[31:16] = bus.CMD_ADDR[15:0];
         2'd3: frame[31:8]  = bus.CMD_ADDR;
      endcase
      if (bus.CMD_HAS_DATA) begin
         case (bus.CMD_ADDR_BYTES)
            2'd0: frame[31:24] = bus.CMD_DATA;
            2'd1: frame[23:16] = bus.CMD_DATA;
            2'd2: frame[15:8]  = bus.CMD_DATA;
            2'd3: frame[7:0]   = bus.CMD_DATA;
         endcase
      end
      frame_len = 6'd8 + {1'b0, bus.CMD_ADDR_BYTES, 3'b000} + {2'b00, bus.CMD_HAS_DATA, 3'b000};
   end

   // Next-state logic; pin values are derived from the next state so every output is a flop.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bits_d  = bits_q;
      sh_d    = sh_q;
      done_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.CMD_REQ) begin
               state_d = SETUP;
               cnt_d   = DIV_LOAD;
               sh_d    = frame;
               bits_d  = frame_len;
            end
         end
         SETUP: begin
            if (cnt_q == 16'd0) begin
               state_d = SHIFT_HI;
               cnt_d   = DIV_LOAD;
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
         SHIFT_HI: begin
            if (cnt_q == 16'd0) begin
               // Falling SCK: advance to the next bit; zeros fill in behind so MOSI idles low.
               state_d = SHIFT_LO;
               cnt_d   = DIV_LOAD;
               sh_d    = {sh_q[38:0], 1'b0};
               bits_d  = bits_q - 6'd1;
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
         SHIFT_LO: begin
            if (cnt_q == 16'd0) begin
               if (bits_q != 6'd0) begin
                  state_d = SHIFT_HI;
                  cnt_d   = DIV_LOAD;
               end else begin
                  // The last low phase has already served as CS hold time.
                  state_d = GAP;
                  cnt_d   = GAP_LOAD;
               end
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
         GAP: begin
            if (cnt_q == 16'd0) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
         default: state_d = IDLE;
      endcase
      cs_d   = !(state_d inside {SETUP, SHIFT_HI, SHIFT_LO});
      sck_d  = (state_d == SHIFT_HI);
      busy_d = (state_d != IDLE);
      mosi_d = cs_d ? 1'b0 : sh_d[39];
   end

   // State, counters and registered pin drivers; reset abandons any frame in flight.
   always_ff @(posedge CLK100M) begin
      if (RESET) begin
         state_q <= IDLE;
         cnt_q   <= 16'd0;
         bits_q  <= 6'd0;
         sh_q    <= 40'd0;
         cs_q    <= 1'b1;
         sck_q   <= 1'b0;
         mosi_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bits_q  <= bits_d;
         sh_q    <= sh_d;
         cs_q    <= cs_d;
         sck_q   <= sck_d;
         mosi_q  <= mosi_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign bus.SPI_CS   = cs_q;
   assign bus.SPI_CLK  = sck_q;
   assign bus.SPI_MOSI = mosi_q;
   assign bus.CMD_BUSY = busy_q;
   assign bus.CMD_DONE = done_q;

endmodule

// File: tb/tb_ptmch_spi_gen.sv
// Directed bench for ptmch_spi_gen: default-timing instance plus a CLK_DIV=1/CS_GAP=1 instance.
// Expected frames are queued at issue time and popped when the frame's CMD_DONE is seen.
// Pins are sampled 1 time unit after each rising edge.
module tb_ptmch_spi_gen;

   typedef struct {
      logic [39:0] w;
      int          nb;
   } exp_t;

   logic clk = 1'b0;
   logic rst_a, rst_b, req_a, req_b;
   logic [7:0]  c_op, c_data;
   logic [23:0] c_addr;
   logic [1:0]  c_bytes;
   logic        c_hd;

   ptmch_spi_gen_if ifa ();
   ptmch_spi_gen_if ifb ();

   assign ifa.CMD_REQ = req_a;
   assign ifa.CMD_OPCODE = c_op;
   assign ifa.CMD_ADDR = c_addr;
   assign ifa.CMD_ADDR_BYTES = c_bytes;
   assign ifa.CMD_HAS_DATA = c_hd;
   assign ifa.CMD_DATA = c_data;
   assign ifb.CMD_REQ = req_b;
   assign ifb.CMD_OPCODE = c_op;
   assign ifb.CMD_ADDR = c_addr;
   assign ifb.CMD_ADDR_BYTES = c_bytes;
   assign ifb.CMD_HAS_DATA = c_hd;
   assign ifb.CMD_DATA = c_data;

   ptmch_spi_gen #(.CLK_DIV(4), .CS_GAP(4)) dut_a (.CLK100M(clk), .RESET(rst_a), .bus(ifa));
   ptmch_spi_gen #(.CLK_DIV(1), .CS_GAP(1)) dut_b (.CLK100M(clk), .RESET(rst_b), .bus(ifb));

   always #5 clk = ~clk;

   exp_t sb[$];
   int total = 0, bad = 0;
   int sel = 0;
   int cyc, rises, cs_low, first_rise, last_rise, per_bad, edge_idle, mosi_idle;
   int done_cyc, done_cnt, hi_run = 0, last_gap = 0;
   bit done_seen;
   logic [39:0] word;
   logic s_cs, s_sck, s_mosi, s_busy, s_done;
   logic sck_prev = 1'b0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic int cur_div();
      return (sel != 0) ? 1 : 4;
   endfunction

   // One clock: advance, then sample the selected instance and update the frame monitor.
   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      s_cs   = (sel != 0) ? ifb.SPI_CS   : ifa.SPI_CS;
      s_sck  = (sel != 0) ? ifb.SPI_CLK  : ifa.SPI_CLK;
      s_mosi = (sel != 0) ? ifb.SPI_MOSI : ifa.SPI_MOSI;
      s_busy = (sel != 0) ? ifb.CMD_BUSY : ifa.CMD_BUSY;
      s_done = (sel != 0) ? ifb.CMD_DONE : ifa.CMD_DONE;
      if (s_cs === 1'b0) begin
         cs_low++;
         if (hi_run != 0) last_gap = hi_run;
         hi_run = 0;
      end else begin
         hi_run++;
      end
      if (s_sck === 1'b1 && sck_prev === 1'b0) begin
         rises++;
         word = {word[38:0], s_mosi};
         if (rises == 1) first_rise = cyc;
         else if (cyc - last_rise != 2 * cur_div()) per_bad++;
         last_rise = cyc;
      end
      if (s_sck !== sck_prev && s_cs === 1'b1) edge_idle++;
      if (s_cs === 1'b1 && s_mosi !== 1'b0) mosi_idle++;
      if (s_done === 1'b1) begin
         done_seen = 1'b1;
         done_cyc  = cyc;
         done_cnt++;
      end
      sck_prev = s_sck;
   endtask

   task automatic clear_capture();
      cyc = 0; rises = 0; cs_low = 0; first_rise = 0; last_rise = 0;
      per_bad = 0; edge_idle = 0; mosi_idle = 0; done_seen = 1'b0; done_cyc = 0;
      word = 40'd0;
   endtask

   // Present a command, queue its expected frame, clock the acceptance edge, check cycle 1.
   task automatic issue(input string tag, input logic [7:0] op, input logic [23:0] addr,
                        input logic [1:0] nbytes, input logic hd, input logic [7:0] d,
                        input bit hold, input logic [39:0] exp_w);
      exp_t e;
      c_op = op; c_addr = addr; c_bytes = nbytes; c_hd = hd; c_data = d;
      if (sel != 0) req_b = 1'b1; else req_a = 1'b1;
      e.w  = exp_w;
      e.nb = 8 * (1 + int'(nbytes) + int'(hd));
      sb.push_back(e);
      clear_capture();
      step();
      if (!hold) begin
         req_a = 1'b0;
         req_b = 1'b0;
      end
      chk({tag, ":cs_c1"}, s_cs, 1'b0);
      chk({tag, ":busy_c1"}, s_busy, 1'b1);
      chk({tag, ":mosi_c1"}, s_mosi, exp_w[e.nb - 1]);
   endtask

   // Clock until CMD_DONE (bounded), then compare the captured frame with the queued expectation.
   task automatic run_to_done(input string tag);
      exp_t e;
      int n = 0;
      int div = cur_div();
      int gap = cur_div();
      int cs_exp;
      while (!done_seen && n < 3000) begin
         step();
         n++;
      end
      e = sb.pop_front();
      cs_exp = div * (1 + 2 * e.nb);
      chk({tag, ":done_seen"}, done_seen, 1'b1);
      chk({tag, ":rises"}, rises, e.nb);
      chk({tag, ":word"}, word, e.w);
      chk({tag, ":cs_low"}, cs_low, cs_exp);
      chk({tag, ":done_cyc"}, done_cyc, 1 + cs_exp + gap);
      chk({tag, ":first_rise"}, first_rise, 1 + div);
      chk({tag, ":sck_period"}, per_bad, 0);
      chk({tag, ":edge_cs_hi"}, edge_idle, 0);
      chk({tag, ":mosi_cs_hi"}, mosi_idle, 0);
      chk({tag, ":busy_at_done"}, s_busy, 1'b0);
   endtask

   initial begin
      rst_a = 1'b1; rst_b = 1'b1; req_a = 1'b0; req_b = 1'b0;
      c_op = 8'h00; c_addr = 24'h0; c_bytes = 2'd0; c_hd = 1'b0; c_data = 8'h00;
      clear_capture();
      repeat (3) step();
      chk("reset:cs", ifa.SPI_CS, 1'b1);
      chk("reset:sck", ifa.SPI_CLK, 1'b0);
      chk("reset:mosi", ifa.SPI_MOSI, 1'b0);
      chk("reset:busy", ifa.CMD_BUSY, 1'b0);
      chk("reset:done", ifa.CMD_DONE, 1'b0);
      chk("reset_b:cs", ifb.SPI_CS, 1'b1);
      chk("reset_b:busy", ifb.CMD_BUSY, 1'b0);
      rst_a = 1'b0; rst_b = 1'b0;
      repeat (2) step();

      // Read status with one address byte.
      issue("rdsr", 8'h0F, 24'h0000C0, 2'd1, 1'b0, 8'h00, 1'b0, 40'h0FC0);
      run_to_done("rdsr");

      // Page data read, three address bytes.
      issue("pdr", 8'h13, 24'h012345, 2'd3, 1'b0, 8'h00, 1'b0, 40'h13012345);
      run_to_done("pdr");

      // Opcode only, then write status with a data byte.
      issue("op_only", 8'h06, 24'hFFFFFF, 2'd0, 1'b0, 8'hFF, 1'b0, 40'h06);
      run_to_done("op_only");
      issue("wrsr", 8'h1F, 24'h0000A0, 2'd1, 1'b1, 8'h38, 1'b0, 40'h1FA038);
      run_to_done("wrsr");

      // Request held high: the second frame is accepted on the CMD_DONE cycle.
      issue("b2b1", 8'h05, 24'h0, 2'd0, 1'b0, 8'h00, 1'b1, 40'h05);
      c_op = 8'h9F;
      run_to_done("b2b1");
      issue("b2b2", 8'h9F, 24'h0, 2'd0, 1'b0, 8'h00, 1'b0, 40'h9F);
      // CS stays high through the GAP cycles plus the idle cycle that carries CMD_DONE.
      chk("b2b:cs_high_gap", last_gap, 4 + 1);
      repeat (20) step();
      c_op = 8'hAA; c_bytes = 2'd2;
      req_a = 1'b1;
      step();
      req_a = 1'b0;
      run_to_done("b2b2");
      clear_capture();
      repeat (60) step();
      chk("busy_pulse:no_frame_cs", cs_low, 0);
      chk("busy_pulse:no_frame_sck", rises, 0);

      // Reset at the 10th SCK rise of a 40-bit frame.
      issue("pre_rst", 8'h02, 24'hABCDEF, 2'd3, 1'b1, 8'h5A, 1'b0, 40'h02ABCDEF5A);
      void'(sb.pop_back());
      begin
         int n = 0;
         while (rises < 10 && n < 1000) begin
            step();
            n++;
         end
      end
      chk("rst:reach10", rises, 10);
      done_cnt = 0;
      rst_a = 1'b1;
      step();
      chk("rst:cs", s_cs, 1'b1);
      chk("rst:sck", s_sck, 1'b0);
      chk("rst:mosi", s_mosi, 1'b0);
      chk("rst:busy", s_busy, 1'b0);
      chk("rst:done", s_done, 1'b0);
      rst_a = 1'b0;
      cs_low = 0;
      repeat (40) step();
      chk("rst:no_done", done_cnt, 0);
      chk("rst:no_resume", cs_low, 0);
      issue("post_rst", 8'h10, 24'h000042, 2'd3, 1'b0, 8'h00, 1'b0, 40'h10000042);
      run_to_done("post_rst");

      // Fastest setting on the second instance.
      sel = 1;
      repeat (2) step();
      issue("fast", 8'hD8, 24'h00FF00, 2'd3, 1'b0, 8'h00, 1'b0, 40'hD800FF00);
      run_to_done("fast");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
